// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: ALU, memory-path, hazard and register-file signals of the writeback arbiter
interface wb_arbiter_if #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 5
);
  logic                alu_valid;
  logic [ADDR_LEN-1:0] alu_dest;
  logic [WORD_LEN-1:0] alu_val;
  logic                alu_stall;
  logic                mem_valid;
  logic [ADDR_LEN-1:0] mem_dest;
  logic [WORD_LEN-1:0] mem_val;
  logic                mem_ready;
  logic [ADDR_LEN-1:0] src1;
  logic [ADDR_LEN-1:0] src2;
  logic                busy1;
  logic                busy2;
  logic                wb_en;
  logic [ADDR_LEN-1:0] wb_dest;
  logic [WORD_LEN-1:0] wb_val;
  modport master (
    output alu_valid, alu_dest, alu_val, mem_valid, mem_dest, mem_val, src1, src2,
    input  alu_stall, mem_ready, busy1, busy2, wb_en, wb_dest, wb_val
  );
  modport slave (
    input  alu_valid, alu_dest, alu_val, mem_valid, mem_dest, mem_val, src1, src2,
    output alu_stall, mem_ready, busy1, busy2, wb_en, wb_dest, wb_val
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the ALU path and a buffered memory path onto the register-file write port
module wb_arbiter #(
  parameter int WORD_LEN     = 32,
  parameter int ADDR_LEN     = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [ADDR_LEN-1:0] r_dest [DEPTH];
  logic [WORD_LEN-1:0] r_val  [DEPTH];
  logic [DEPTH-1:0]    r_vld;
  logic [PW-1:0]       r_rd, r_wr;
  logic [CW-1:0]       r_cnt;
  logic [SW-1:0]       r_starve;
  logic                r_wb_en;
  logic [ADDR_LEN-1:0] r_wb_dest;
  logic [WORD_LEN-1:0] r_wb_val;
  logic                w_full, w_skip, w_cand_vld, w_cand_sq, w_stall, w_alu_go, w_pop, w_push, w_store;
  logic [PW-1:0]       w_cand;
  logic [DEPTH-1:0]    w_sq;
  logic                w_b1, w_b2;
  // an invalid (squashed) head is dropped for free, so the issue candidate is the entry behind it
  assign w_full     = r_cnt == CW'(DEPTH);
  assign w_skip     = r_cnt != '0 && !r_vld[r_rd];
  assign w_cand     = r_rd + PW'(w_skip);
  assign w_cand_vld = r_vld[w_cand];
  assign w_stall    = !rst && r_starve == SW'(STARVE_LIMIT);
  assign w_alu_go   = !w_stall && bus.alu_valid && bus.alu_dest != '0;
  assign w_pop      = w_stall || (!w_alu_go && w_cand_vld);
  assign w_cand_sq  = w_alu_go && r_dest[w_cand] == bus.alu_dest;
  assign w_push     = bus.mem_valid && bus.mem_ready;
  assign w_store    = w_push && bus.mem_dest != '0 && !(w_alu_go && bus.mem_dest == bus.alu_dest);
  // squash mask and hazard flags over all queued entries
  always_comb begin
    w_sq = '0;
    w_b1 = 1'b0;
    w_b2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sq[i] = w_alu_go && r_dest[i] == bus.alu_dest;
      w_b1 = w_b1 | (r_vld[i] && r_dest[i] == bus.src1);
      w_b2 = w_b2 | (r_vld[i] && r_dest[i] == bus.src2);
    end
  end
  // FIFO control: valid bits, pointers, occupancy and the head starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_sq[i]) r_vld[i] <= 1'b0;
      if (w_pop) r_vld[w_cand] <= 1'b0;
      if (w_store) r_vld[r_wr] <= 1'b1;
      r_wr     <= r_wr + PW'(w_store);
      r_rd     <= r_rd + PW'(w_skip) + PW'(w_pop);
      r_cnt    <= r_cnt + CW'(w_store) - CW'(w_skip) - CW'(w_pop);
      r_starve <= (w_pop || !w_cand_vld || w_cand_sq) ? '0 : r_starve + SW'(1);
    end
  end
  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_dest[r_wr] <= bus.mem_dest;
      r_val[r_wr]  <= bus.mem_val;
    end
  end
  // registered write port; dest/value hold when nothing issues
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_en   <= 1'b0;
      r_wb_dest <= '0;
      r_wb_val  <= '0;
    end else begin
      r_wb_en   <= w_alu_go || w_pop;
      r_wb_dest <= w_alu_go ? bus.alu_dest : w_pop ? r_dest[w_cand] : r_wb_dest;
      r_wb_val  <= w_alu_go ? bus.alu_val  : w_pop ? r_val[w_cand]  : r_wb_val;
    end
  end
  assign bus.alu_stall = w_stall;
  assign bus.mem_ready = !w_full && !rst;
  assign bus.busy1     = !rst && bus.src1 != '0 && w_b1;
  assign bus.busy2     = !rst && bus.src2 != '0 && w_b2;
  assign bus.wb_en     = r_wb_en;
  assign bus.wb_dest   = r_wb_dest;
  assign bus.wb_val    = r_wb_val;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed per-cycle vectors plus reset and latency sequences
module tb_wb_arbiter;
  logic clk, rst;
  int n_tests = 0;
  int n_fail  = 0;
  wb_arbiter_if #(.WORD_LEN(32), .ADDR_LEN(5)) bus();
  wb_arbiter #(.WORD_LEN(32), .ADDR_LEN(5), .DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct packed {
    logic        av;
    logic [4:0]  ad;
    logic [31:0] aval;
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mval;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_stall;
    logic        e_rdy;
    logic        e_b1;
    logic        e_b2;
    logic        e_en;
    logic [4:0]  e_dest;
    logic [31:0] e_val;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(input int av, ad, aval, mv, md, mval, s1, s2,
                              st, rd, b1, b2, en, dst, val);
    vec_t r;
    r.av = av[0];      r.ad = ad[4:0];   r.aval = aval;
    r.mv = mv[0];      r.md = md[4:0];   r.mval = mval;
    r.s1 = s1[4:0];    r.s2 = s2[4:0];
    r.e_stall = st[0]; r.e_rdy = rd[0];  r.e_b1 = b1[0]; r.e_b2 = b2[0];
    r.e_en = en[0];    r.e_dest = dst[4:0]; r.e_val = val;
    return r;
  endfunction
  task automatic drive(input vec_t x);
    bus.alu_valid = x.av; bus.alu_dest = x.ad; bus.alu_val = x.aval;
    bus.mem_valid = x.mv; bus.mem_dest = x.md; bus.mem_val = x.mval;
    bus.src1 = x.s1; bus.src2 = x.s2;
  endtask
  task automatic step(input int av, ad, aval, mv, md, mval, s1, s2);
    @(negedge clk);
    drive(mk(av, ad, aval, mv, md, mval, s1, s2, 0, 0, 0, 0, 0, 0, 0));
    #1;
  endtask
  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h want 0x%0h", nm, row, act, exp);
    end
  endtask
  initial begin
    // inputs of cycle N; wb_* columns show the decision of cycle N-1
    v.push_back(mk(1, 3,'h11, 0,0,0,      0,0,  0,1,0,0, 0,0,0));
    v.push_back(mk(1, 0,'h22, 0,0,0,      0,0,  0,1,0,0, 1,3,'h11));
    v.push_back(mk(1, 7,'h33, 0,0,0,      0,0,  0,1,0,0, 0,0,0));
    v.push_back(mk(0, 0,0,    0,0,0,      0,0,  0,1,0,0, 1,7,'h33));
    v.push_back(mk(0, 0,0,    0,0,0,      0,0,  0,1,0,0, 0,0,0));
    v.push_back(mk(1,10,'hB0, 1,1,'hA1,   2,0,  0,1,0,0, 0,0,0));
    v.push_back(mk(1,10,'hB1, 1,2,'hA2,   2,0,  0,1,0,0, 1,10,'hB0));
    v.push_back(mk(1,10,'hB2, 1,4,'hA4,   2,0,  0,1,1,0, 1,10,'hB1));
    v.push_back(mk(1,10,'hB3, 1,5,'hA5,   2,0,  0,1,1,0, 1,10,'hB2));
    v.push_back(mk(1,10,'hB4, 1,6,'hA6,   2,0,  1,0,1,0, 1,10,'hB3));
    v.push_back(mk(1,10,'hB4, 0,0,0,      2,0,  0,1,1,0, 1,1,'hA1));
    v.push_back(mk(0, 0,0,    0,0,0,      2,0,  0,1,1,0, 1,10,'hB4));
    v.push_back(mk(0, 0,0,    0,0,0,      2,0,  0,1,0,0, 1,2,'hA2));
    v.push_back(mk(0, 0,0,    0,0,0,      2,0,  0,1,0,0, 1,4,'hA4));
    v.push_back(mk(0, 0,0,    0,0,0,      2,0,  0,1,0,0, 1,5,'hA5));
    v.push_back(mk(0, 0,0,    0,0,0,      2,0,  0,1,0,0, 0,0,0));
    v.push_back(mk(0, 0,0,    1,9,'hAA,   9,0,  0,1,0,0, 0,0,0));
    v.push_back(mk(1, 6,'hC0, 0,0,0,      9,0,  0,1,1,0, 0,0,0));
    v.push_back(mk(1, 6,'hC1, 0,0,0,      9,0,  0,1,1,0, 1,6,'hC0));
    v.push_back(mk(1, 6,'hC2, 0,0,0,      9,0,  0,1,1,0, 1,6,'hC1));
    v.push_back(mk(1, 6,'hC3, 0,0,0,      9,0,  1,1,1,0, 1,6,'hC2));
    v.push_back(mk(1, 6,'hC3, 0,0,0,      9,0,  0,1,0,0, 1,9,'hAA));
    v.push_back(mk(0, 0,0,    0,0,0,      9,0,  0,1,0,0, 1,6,'hC3));
    v.push_back(mk(0, 0,0,    0,0,0,      9,0,  0,1,0,0, 0,0,0));
    v.push_back(mk(0, 0,0,    1,8,1,      8,11, 0,1,0,0, 0,0,0));
    v.push_back(mk(1,12,'hE,  1,11,4,     8,11, 0,1,1,0, 0,0,0));
    v.push_back(mk(1, 8,2,    1,8,3,      8,11, 0,1,1,1, 1,12,'hE));
    v.push_back(mk(0, 0,0,    0,0,0,      8,11, 0,1,0,1, 1,8,2));
    v.push_back(mk(0, 0,0,    0,0,0,      8,11, 0,1,0,0, 1,11,4));
    v.push_back(mk(0, 0,0,    0,0,0,      8,11, 0,1,0,0, 0,0,0));
    v.push_back(mk(1, 0,'h66, 1,0,'h55,   0,0,  0,1,0,0, 0,0,0));
    v.push_back(mk(0, 0,0,    0,0,0,      0,0,  0,1,0,0, 0,0,0));
    v.push_back(mk(0, 0,0,    0,0,0,      0,0,  0,1,0,0, 0,0,0));
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); #1;
    chk("rst_mem_ready", -1, 32'(bus.mem_ready), 0);
    chk("rst_alu_stall", -1, 32'(bus.alu_stall), 0);
    @(negedge clk); #1;
    chk("rst_wb_en", -1, 32'(bus.wb_en), 0);
    chk("rst_wb_dest", -1, 32'(bus.wb_dest), 0);
    chk("rst_wb_val", -1, bus.wb_val, 0);
    rst = 1'b0;
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      chk("alu_stall", i, 32'(bus.alu_stall), 32'(v[i].e_stall));
      chk("mem_ready", i, 32'(bus.mem_ready), 32'(v[i].e_rdy));
      chk("busy1", i, 32'(bus.busy1), 32'(v[i].e_b1));
      chk("busy2", i, 32'(bus.busy2), 32'(v[i].e_b2));
      chk("wb_en", i, 32'(bus.wb_en), 32'(v[i].e_en));
      if (v[i].e_en) begin
        chk("wb_dest", i, 32'(bus.wb_dest), 32'(v[i].e_dest));
        chk("wb_val", i, bus.wb_val, v[i].e_val);
      end
    end
    step(1, 10, 'h70, 1, 1, 'h71, 1, 2);
    step(1, 10, 'h72, 1, 2, 'h72, 1, 2);
    step(1, 10, 'h73, 1, 3, 'h73, 1, 2);
    chk("pre_rst_busy1", 100, 32'(bus.busy1), 1);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0, 0, 0, 1, 4, 'h74, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("midrst_mem_ready", 101, 32'(bus.mem_ready), 0);
    chk("midrst_alu_stall", 101, 32'(bus.alu_stall), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("postrst_wb_en", 102, 32'(bus.wb_en), 0);
    chk("postrst_wb_dest", 102, 32'(bus.wb_dest), 0);
    chk("postrst_wb_val", 102, bus.wb_val, 0);
    chk("postrst_busy1", 102, 32'(bus.busy1), 0);
    chk("postrst_busy2", 102, 32'(bus.busy2), 0);
    chk("postrst_mem_ready", 102, 32'(bus.mem_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 2);
      chk("postrst_quiet", 103 + i, 32'(bus.wb_en), 0);
    end
    step(0, 0, 0, 1, 5, 'h99, 5, 0);
    chk("lat_busy_empty", 106, 32'(bus.busy1), 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    chk("lat_busy_queued", 107, 32'(bus.busy1), 1);
    chk("lat_wb_en_early", 107, 32'(bus.wb_en), 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    chk("lat_wb_en", 108, 32'(bus.wb_en), 1);
    chk("lat_wb_dest", 108, 32'(bus.wb_dest), 5);
    chk("lat_wb_val", 108, bus.wb_val, 'h99);
    chk("lat_busy_done", 108, 32'(bus.busy1), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
